// File: rtl/axis_ptp_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axis_ptp_frame_gen
//  Description : Wishbone-configured generator of short PTP-style frames
//                (4-byte header + patterned payload) on a byte-wide AXIS
//                master port. Configuration is snapshotted at frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_ptp_frame_gen #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0100,
    parameter int          DATA_WIDTH = 8,   // only 8 is supported
    parameter int          USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wbs_addr_i,
    input  logic [31:0]           wbs_data_i,
    output logic [31:0]           wbs_data_o,
    input  logic                  wbs_we_i,
    input  logic                  wbs_stb_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] OFF_CTRL = 32'h00;
    localparam logic [31:0] OFF_HDR  = 32'h04;
    localparam logic [31:0] OFF_LEN  = 32'h0C;
    localparam logic [31:0] OFF_PAT  = 32'h10;
    localparam logic [31:0] OFF_FCNT = 32'h14;

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;            // header byte currently on the bus
    logic [7:0]  cnt, cnt_nxt;            // payload bytes left incl. current
    logic        sel_lo, sel_lo_nxt;      // next payload byte uses PATTERN[7:0]
    logic [DATA_WIDTH-1:0] tdata_reg, tdata_nxt;
    logic        tvalid_reg, tvalid_nxt;
    logic        tlast_reg, tlast_nxt;

    logic        auto_inc;
    logic [31:0] hdr_reg, fcnt;
    logic [7:0]  len_reg, sh_len;
    logic [15:0] pat_reg, sh_pat;
    logic [31:0] sh_hdr;

    logic        stb_seen;                // blocks re-ack until stb drops
    logic [31:0] offset, rdata;
    logic        acc, wr, start, busy, hs;
    logic [1:0]  idx_inc;

    assign offset  = wbs_addr_i - BASE_ADDR;
    assign acc     = wbs_stb_i && !stb_seen;
    assign wr      = acc && wbs_we_i;
    assign busy    = (state != ST_IDLE);
    // START only launches a frame from IDLE; while busy it is acked and dropped
    assign start   = wr && (offset == OFF_CTRL) && wbs_data_i[0] && !busy;
    assign hs      = tvalid_reg && m_axis_tready;
    assign idx_inc = idx + 2'd1;

    // Wire order of the header: ethertype MSB first, then msg_type/seq_id
    function automatic logic [7:0] hdr_byte(input logic [31:0] h, input logic [1:0] i);
        case (i)
            2'd0:    hdr_byte = h[15:8];
            2'd1:    hdr_byte = h[7:0];
            2'd2:    hdr_byte = h[31:24];
            default: hdr_byte = h[23:16];
        endcase
    endfunction

    // Register read mux, sampled on the ack edge
    always_comb begin
        rdata = 32'h0;
        case (offset)
            OFF_CTRL: rdata = {23'h0, busy, 6'h0, auto_inc, 1'b0};
            OFF_HDR:  rdata = hdr_reg;
            OFF_LEN:  rdata = {24'h0, len_reg};
            OFF_PAT:  rdata = {16'h0, pat_reg};
            OFF_FCNT: rdata = fcnt;
            default:  rdata = 32'h0;
        endcase
    end

    // Wishbone handshake: one-cycle ack, re-armed only after stb is seen low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= 32'h0;
            stb_seen   <= 1'b0;
        end else if (acc) begin
            wbs_ack_o  <= 1'b1;
            wbs_data_o <= rdata;
            stb_seen   <= 1'b1;
        end else begin
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= 32'h0;
            if (!wbs_stb_i)
                stb_seen <= 1'b0;
        end
    end

    // Config registers, frame counter and start-of-frame shadow copies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_inc <= 1'b0;
            hdr_reg  <= 32'h0;
            len_reg  <= 8'h0;
            pat_reg  <= 16'h0;
            fcnt     <= 32'h0;
            sh_hdr   <= 32'h0;
            sh_len   <= 8'h0;
            sh_pat   <= 16'h0;
        end else begin
            if (state == ST_DONE) begin
                fcnt <= fcnt + 32'd1;
                if (auto_inc)
                    hdr_reg[27:16] <= hdr_reg[27:16] + 12'd1;
            end
            // A software write lands after the increment so it wins the tie
            if (wr) begin
                case (offset)
                    OFF_CTRL: auto_inc <= wbs_data_i[1];
                    OFF_HDR:  hdr_reg  <= wbs_data_i;
                    OFF_LEN:  len_reg  <= wbs_data_i[7:0];
                    OFF_PAT:  pat_reg  <= wbs_data_i[15:0];
                    default:  ;
                endcase
            end
            if (start) begin
                sh_hdr <= hdr_reg;
                sh_len <= len_reg;
                sh_pat <= pat_reg;
            end
        end
    end

    // FSM state and registered AXIS outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            cnt        <= 8'd0;
            sel_lo     <= 1'b0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            sel_lo     <= sel_lo_nxt;
            tdata_reg  <= tdata_nxt;
            tvalid_reg <= tvalid_nxt;
            tlast_reg  <= tlast_nxt;
        end
    end

    // Next-state and next-byte logic; the bus only changes on a handshake
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        sel_lo_nxt = sel_lo;
        tdata_nxt  = tdata_reg;
        tvalid_nxt = tvalid_reg;
        tlast_nxt  = tlast_reg;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_HDR;
                    idx_nxt   = 2'd0;
                end
            end
            ST_HDR: begin
                if (!tvalid_reg) begin
                    tdata_nxt  = hdr_byte(sh_hdr, idx);
                    tvalid_nxt = 1'b1;
                    tlast_nxt  = (idx == 2'd3) && (sh_len == 8'd0);
                end else if (hs) begin
                    if (idx == 2'd3) begin
                        if (sh_len != 8'd0) begin
                            state_nxt  = ST_PAY;
                            cnt_nxt    = sh_len;
                            sel_lo_nxt = 1'b1;
                            tdata_nxt  = sh_pat[15:8];
                            tlast_nxt  = (sh_len == 8'd1);
                        end else begin
                            state_nxt  = ST_DONE;
                            tvalid_nxt = 1'b0;
                            tlast_nxt  = 1'b0;
                        end
                    end else begin
                        idx_nxt   = idx_inc;
                        tdata_nxt = hdr_byte(sh_hdr, idx_inc);
                        tlast_nxt = (idx_inc == 2'd3) && (sh_len == 8'd0);
                    end
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (cnt == 8'd1) begin
                        state_nxt  = ST_DONE;
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                    end else begin
                        cnt_nxt    = cnt - 8'd1;
                        sel_lo_nxt = !sel_lo;
                        tdata_nxt  = sel_lo ? sh_pat[7:0] : sh_pat[15:8];
                        tlast_nxt  = (cnt == 8'd2);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tuser  = '0;

endmodule
`default_nettype wire

// File: tb/tb_axis_ptp_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_ptp_frame_gen
//  Description : Directed self-checking bench for axis_ptp_frame_gen
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_ptp_frame_gen;

    localparam logic [31:0] BASE = 32'h0300_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wbs_addr_i = '0;
    logic [31:0] wbs_data_i = '0;
    logic [31:0] wbs_data_o;
    logic        wbs_we_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_ack_o;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    axis_ptp_frame_gen #(
        .BASE_ADDR (BASE),
        .DATA_WIDTH(8),
        .USER_WIDTH(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wbs_addr_i   (wbs_addr_i),
        .wbs_data_i   (wbs_data_i),
        .wbs_data_o   (wbs_data_o),
        .wbs_we_i     (wbs_we_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_ack_o    (wbs_ack_o),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
        int t;
        @(negedge clk);
        wbs_addr_i = BASE + off;
        wbs_data_i = d;
        wbs_we_i   = 1'b1;
        wbs_stb_i  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wbs_ack_o && t < 8);
        chk($sformatf("wr_ack_%0h", off), 32'(wbs_ack_o), 32'd1);
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] d);
        int t;
        @(negedge clk);
        wbs_addr_i = BASE + off;
        wbs_we_i   = 1'b0;
        wbs_stb_i  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wbs_ack_o && t < 8);
        chk($sformatf("rd_ack_%0h", off), 32'(wbs_ack_o), 32'd1);
        d = wbs_data_o;
        wbs_stb_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(off, d);
        chk(tag, d, exp);
    endtask

    // Receive one frame and compare it with the expected byte list
    task automatic collect(input string tag, input bit bp, input logic [31:0] hdr,
                           input int len, input logic [15:0] pat);
        logic [7:0] e[$];
        logic [7:0] got[$];
        logic [7:0] pd;
        logic       pl;
        bit         stall, seen_last;
        int         cyc;
        logic [31:0] g;
        e.push_back(hdr[15:8]);
        e.push_back(hdr[7:0]);
        e.push_back(hdr[31:24]);
        e.push_back(hdr[23:16]);
        for (int k = 0; k < len; k++)
            e.push_back((k % 2 == 1) ? pat[7:0] : pat[15:8]);
        stall = 0; seen_last = 0; cyc = 0; pd = '0; pl = 1'b0;
        while (!seen_last && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                chk({tag, "_hold_v"}, 32'(m_axis_tvalid), 32'd1);
                chk({tag, "_hold_d"}, 32'(m_axis_tdata), 32'(pd));
                chk({tag, "_hold_l"}, 32'(m_axis_tlast), 32'(pl));
            end
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back(m_axis_tdata);
                if (m_axis_tlast) seen_last = 1;
                stall = 0;
            end else begin
                stall = m_axis_tvalid;
            end
            pd = m_axis_tdata;
            pl = m_axis_tlast;
        end
        chk({tag, "_tlast_seen"}, 32'(seen_last), 32'd1);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            g = (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
            chk($sformatf("%s_b%0d", tag, i), g, 32'(e[i]));
        end
        @(negedge clk);
        m_axis_tready = 1'b0;
        chk({tag, "_idle_after"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",    32'(wbs_ack_o), 32'd0);
        chk("rst_rdata",  wbs_data_o, 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast",  32'(m_axis_tlast), 32'd0);
        chk("rst_tdata",  32'(m_axis_tdata), 32'd0);
        chk("rst_tuser",  32'(m_axis_tuser), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_ctrl", 32'h00, 32'h0);
        rd_chk("rst_hdr",  32'h04, 32'h0);
        rd_chk("rst_fcnt", 32'h14, 32'h0);
        rd_chk("oob_read", 32'h40, 32'h0);

        // ---------------- basic frame ----------------
        wb_write(32'h04, 32'h1123_5555);
        wb_write(32'h0C, 32'h0000_0016);
        wb_write(32'h10, 32'h0000_AAAA);
        wb_write(32'h08, 32'hFFFF_FFFF);
        rd_chk("rsvd_read", 32'h08, 32'h0);
        rd_chk("len_read",  32'h0C, 32'h16);
        wb_write(32'h00, 32'h1);
        chk("start_lat0", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        chk("start_lat1", 32'(m_axis_tvalid), 32'd1);
        chk("start_b0",   32'(m_axis_tdata), 32'h55);
        collect("basic", 1'b0, 32'h1123_5555, 22, 16'hAAAA);
        rd_chk("basic_fcnt", 32'h14, 32'd1);
        rd_chk("basic_ctrl", 32'h00, 32'h0);

        // ---------------- backpressure ----------------
        wb_write(32'h00, 32'h1);
        collect("bp", 1'b1, 32'h1123_5555, 22, 16'hAAAA);
        rd_chk("bp_fcnt", 32'h14, 32'd2);

        // ---------------- pattern, LEN=3 ----------------
        wb_write(32'h10, 32'h0000_5AA5);
        wb_write(32'h0C, 32'h3);
        wb_write(32'h00, 32'h1);
        collect("pat3", 1'b0, 32'h1123_5555, 3, 16'h5AA5);

        // ---------------- LEN=0 ----------------
        wb_write(32'h0C, 32'h0);
        wb_write(32'h00, 32'h1);
        collect("len0", 1'b0, 32'h1123_5555, 0, 16'h5AA5);
        rd_chk("len0_fcnt", 32'h14, 32'd4);

        // ---------------- AUTO_INC and seq_id wrap ----------------
        wb_write(32'h04, 32'h1FFF_88F7);
        wb_write(32'h00, 32'h2);
        rd_chk("auto_ctrl", 32'h00, 32'h2);
        wb_write(32'h00, 32'h3);
        collect("auto1", 1'b0, 32'h1FFF_88F7, 0, 16'h5AA5);
        rd_chk("auto_hdr1", 32'h04, 32'h1000_88F7);
        wb_write(32'h00, 32'h3);
        collect("auto2", 1'b0, 32'h1000_88F7, 0, 16'h5AA5);
        rd_chk("auto_hdr2", 32'h04, 32'h1001_88F7);
        wb_write(32'h00, 32'h0);

        // ---------------- busy behaviour ----------------
        wb_write(32'h04, 32'hA0BC_1234);
        wb_write(32'h0C, 32'h5);
        wb_write(32'h00, 32'h1);
        rd_chk("busy_ctrl", 32'h00, 32'h100);
        wb_write(32'h00, 32'h1);
        wb_write(32'h04, 32'h30DE_4321);
        collect("busy1", 1'b0, 32'hA0BC_1234, 5, 16'h5AA5);
        repeat (4) @(negedge clk);
        chk("busy_no_extra", 32'(m_axis_tvalid), 32'd0);
        rd_chk("busy_ctrl_idle", 32'h00, 32'h0);
        wb_write(32'h00, 32'h1);
        collect("busy2", 1'b0, 32'h30DE_4321, 5, 16'h5AA5);
        rd_chk("busy_fcnt", 32'h14, 32'd8);

        // ---------------- reset mid-payload ----------------
        wb_write(32'h0C, 32'h16);
        wb_write(32'h00, 32'h1);
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            m_axis_tready = 1'b1;
            if (m_axis_tvalid) n++;
        end
        chk("mid_count", 32'(n), 32'd10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_tlast",  32'(m_axis_tlast), 32'd0);
        m_axis_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd_chk("mid_ctrl", 32'h00, 32'h0);
        rd_chk("mid_hdr",  32'h04, 32'h0);
        rd_chk("mid_len",  32'h0C, 32'h0);
        rd_chk("mid_pat",  32'h10, 32'h0);
        rd_chk("mid_fcnt", 32'h14, 32'h0);
        wb_write(32'h04, 32'h1123_5555);
        wb_write(32'h0C, 32'h3);
        wb_write(32'h10, 32'h5AA5);
        wb_write(32'h00, 32'h1);
        collect("post", 1'b0, 32'h1123_5555, 3, 16'h5AA5);
        rd_chk("post_fcnt", 32'h14, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
